// File: rtl/sram_arbiter.sv
// Three-way arbiter in front of the single-port SRAM controller: video has fixed priority,
// draw and erase alternate, and a wait counter forces draw/erase ahead after long video bursts.
module sram_arbiter #(
    parameter int AW       = 18,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2:0]    req,
    input  logic [2:0]    we,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    input  logic [DW-1:0] wdata2,
    output logic [2:0]    gnt,
    output logic [2:0]    done,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] address,
    output logic [DW-1:0] data_write,
    output logic          read,
    output logic          write,
    input  logic          ready,
    input  logic [DW-1:0] data_read,
    output logic          busy
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state_q, state_d;
    logic          issue_cnt_q, issue_cnt_d;
    logic [1:0]    owner_q, owner_d;
    logic          we_q, we_d;
    logic          rr_ptr_q, rr_ptr_d;     // 1 = draw favoured, 0 = erase favoured
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]    gnt_q, gnt_d;
    logic [2:0]    done_q, done_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] data_write_q, data_write_d;
    logic          read_q, read_d;
    logic          write_q, write_d;

    logic [AW-1:0] addr_arr  [3];
    logic [DW-1:0] wdata_arr [3];
    logic          rr_req;
    logic          starve;
    logic          complete;
    logic [1:0]    rr_win;
    logic [1:0]    winner;

    assign addr_arr[0]  = addr0;
    assign addr_arr[1]  = addr1;
    assign addr_arr[2]  = addr2;
    assign wdata_arr[0] = wdata0;
    assign wdata_arr[1] = wdata1;
    assign wdata_arr[2] = wdata2;

    assign rr_req = req[1] | req[2];
    assign starve = (wait_cnt_q == WAIT_MAX) && rr_req;
    assign rr_win = rr_ptr_q ? (req[1] ? 2'd1 : 2'd2) : (req[2] ? 2'd2 : 2'd1);
    assign winner = (starve || !req[0]) ? rr_win : 2'd0;

    always_comb begin
        state_d      = state_q;
        issue_cnt_d  = issue_cnt_q;
        owner_d      = owner_q;
        we_d         = we_q;
        rr_ptr_d     = rr_ptr_q;
        wait_cnt_d   = wait_cnt_q;
        rdata_d      = rdata_q;
        address_d    = address_q;
        data_write_d = data_write_q;
        gnt_d        = 3'b000;
        done_d       = 3'b000;
        read_d       = 1'b0;
        write_d      = 1'b0;
        complete     = 1'b0;

        if (!rr_req) begin
            wait_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (ready && (req != 3'b000)) begin
                    address_d     = addr_arr[winner];
                    data_write_d  = wdata_arr[winner];
                    we_d          = we[winner];
                    owner_d       = winner;
                    read_d        = ~we[winner];
                    write_d       = we[winner];
                    gnt_d[winner] = 1'b1;
                    issue_cnt_d   = 1'b0;
                    state_d       = ISSUE;
                    if (winner == 2'd0) begin
                        if (rr_req && (wait_cnt_q != WAIT_MAX)) begin
                            wait_cnt_d = wait_cnt_q + 1'b1;
                        end
                    end else begin
                        wait_cnt_d = '0;
                        rr_ptr_d   = (winner == 2'd2);
                    end
                end
            end
            ISSUE: begin
                // Controller may take one extra cycle to drop ready; a ready still high
                // on the second cycle means the access already finished.
                if (!ready) begin
                    state_d = WAIT;
                end else if (issue_cnt_q) begin
                    complete = 1'b1;
                end else begin
                    issue_cnt_d = 1'b1;
                end
            end
            WAIT: begin
                if (ready) begin
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            done_d[owner_q] = 1'b1;
            if (!we_q) begin
                rdata_d = data_read;
            end
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            issue_cnt_q  <= 1'b0;
            owner_q      <= 2'd0;
            we_q         <= 1'b0;
            rr_ptr_q     <= 1'b1;
            wait_cnt_q   <= '0;
            gnt_q        <= 3'b000;
            done_q       <= 3'b000;
            rdata_q      <= '0;
            address_q    <= '0;
            data_write_q <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            issue_cnt_q  <= issue_cnt_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            rr_ptr_q     <= rr_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            rdata_q      <= rdata_d;
            address_q    <= address_d;
            data_write_q <= data_write_d;
            read_q       <= read_d;
            write_q      <= write_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign address    = address_q;
    assign data_write = data_write_q;
    assign read       = read_q;
    assign write      = write_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural SRAM controller that holds ready low
// for three cycles after each command strobe.
module tb_sram_arbiter;
    localparam int AW = 18;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [2:0]    req = 3'b000;
    logic [2:0]    we = 3'b000;
    logic [AW-1:0] addr0 = '0, addr1 = '0, addr2 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
    logic [2:0]    gnt, done;
    logic [DW-1:0] rdata, data_write, data_read;
    logic [AW-1:0] address;
    logic          read, write, ready, busy;

    always #5 clk = ~clk;

    sram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(8)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
        .gnt(gnt), .done(done), .rdata(rdata), .address(address),
        .data_write(data_write), .read(read), .write(write),
        .ready(ready), .data_read(data_read), .busy(busy)
    );

    // Controller model: read-only memory contents, writes are accepted and discarded.
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            lat;
    logic          m_we;
    logic [AW-1:0] m_a;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ready     <= 1'b1;
            lat       <= 0;
            data_read <= '0;
            m_we      <= 1'b0;
            m_a       <= '0;
        end else if (read || write) begin
            ready <= 1'b0;
            lat   <= 2;
            m_we  <= write;
            m_a   <= address;
        end else if (!ready) begin
            if (lat == 0) begin
                ready <= 1'b1;
                if (!m_we) data_read <= mem.exists(m_a) ? mem[m_a] : '0;
            end else begin
                lat <= lat - 1;
            end
        end
    end

    typedef struct {
        logic [2:0]    g;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } gexp_t;
    typedef struct {
        logic [2:0]    g;
        logic [DW-1:0] r;
    } dexp_t;

    gexp_t gq[$];
    dexp_t dq[$];
    gexp_t ge;
    dexp_t de;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    last_g = -100;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (gnt != 3'b000) begin
                total++;
                if (gq.size() == 0) begin
                    bad++;
                    $display("FAIL gnt_unexpected actual gnt=%b required none", gnt);
                end else begin
                    ge = gq.pop_front();
                    if (gnt !== ge.g || address !== ge.a || write !== ge.w || read !== !ge.w ||
                        (ge.w && data_write !== ge.d)) begin
                        bad++;
                        $display("FAIL grant actual gnt=%b addr=%h rd=%b wr=%b wd=%h required gnt=%b addr=%h wr=%b wd=%h",
                                 gnt, address, read, write, data_write, ge.g, ge.a, ge.w, ge.d);
                    end else begin
                        $display("grant gnt=%b addr=%h rd=%b wr=%b", gnt, address, read, write);
                    end
                end
                total++;
                if (cyc - last_g < 4) begin
                    bad++;
                    $display("FAIL gnt_spacing actual=%0d required>=4", cyc - last_g);
                end
                last_g = cyc;
            end
            if (done != 3'b000) begin
                total++;
                if (dq.size() == 0) begin
                    bad++;
                    $display("FAIL done_unexpected actual done=%b required none", done);
                end else begin
                    de = dq.pop_front();
                    if (done !== de.g || rdata !== de.r) begin
                        bad++;
                        $display("FAIL done actual done=%b rdata=%h required done=%b rdata=%h",
                                 done, rdata, de.g, de.r);
                    end else begin
                        $display("done done=%b rdata=%h", done, rdata);
                    end
                end
            end
            if ((read || write) && gnt == 3'b000) begin
                total++;
                bad++;
                $display("FAIL stray_strobe actual rd=%b wr=%b required no strobe without gnt", read, write);
            end
        end
    end

    task automatic push(input logic [2:0] g, input logic w, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] r, input bit with_done);
        gq.push_back('{g: g, w: w, a: a, d: d});
        if (with_done) dq.push_back('{g: g, r: r});
    endtask

    task automatic check_idle(input string name);
        total++;
        if ({gnt, done, read, write, busy} !== 9'b0 || address !== '0 || data_write !== '0 || rdata !== '0) begin
            bad++;
            $display("FAIL %s actual gnt=%b done=%b rd=%b wr=%b busy=%b addr=%h wd=%h rdata=%h required all zero",
                     name, gnt, done, read, write, busy, address, data_write, rdata);
        end else begin
            $display("%s outputs idle", name);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req   = 3'b000;
        reset = 1'b1;
        #1;
        check_idle("reset_state");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_g = -100;
        @(negedge clk);
    endtask

    // Drive req, collect n grants (optionally dropping each granted bit), then drain.
    task automatic run(input string name, input logic [2:0] r, input int n, input bit drop);
        int seen = 0;
        int budget = 0;
        req = r;
        while (seen < n && budget < 2000) begin
            @(negedge clk);
            budget++;
            if (gnt != 3'b000) begin
                seen++;
                if (drop) req = req & ~gnt;
            end
        end
        req = 3'b000;
        total++;
        if (seen < n) begin
            bad++;
            $display("FAIL %s_grant_timeout actual=%0d required=%0d", name, seen, n);
        end
        budget = 0;
        while ((busy || dq.size() != 0 || gq.size() != 0) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (budget >= 200) begin
            bad++;
            $display("FAIL %s_drain_timeout actual pending_gnt=%0d pending_done=%0d required 0",
                     name, gq.size(), dq.size());
        end
    endtask

    initial begin
        bit saw_done;
        mem[18'h00010] = 16'hBEEF;
        mem[18'h00100] = 16'h1000;
        mem[18'h01111] = 16'h1111;
        mem[18'h02222] = 16'h2222;
        #1 reset = 1'b1;
        #1;
        check_idle("reset_async");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single video read
        we = 3'b000; addr0 = 18'h00010;
        push(3'b001, 1'b0, 18'h00010, 16'h0000, 16'hBEEF, 1'b1);
        run("single_read", 3'b001, 1, 1'b1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_read actual=%b required=0", busy);
        end

        // Draw write: rdata keeps the previous read value
        we = 3'b010; addr1 = 18'h2ABCD; wdata1 = 16'h00FF;
        push(3'b010, 1'b1, 18'h2ABCD, 16'h00FF, 16'hBEEF, 1'b1);
        run("write_route", 3'b010, 1, 1'b1);

        // Round-robin between draw and erase
        do_reset();
        we = 3'b000; addr1 = 18'h01111; addr2 = 18'h02222;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push(3'b010, 1'b0, 18'h01111, 16'h0000, 16'h1111, 1'b1);
            else            push(3'b100, 1'b0, 18'h02222, 16'h0000, 16'h2222, 1'b1);
        end
        run("round_robin", 3'b110, 4, 1'b0);

        // Simultaneous requests: video, then draw, then erase
        do_reset();
        addr0 = 18'h00100;
        push(3'b001, 1'b0, 18'h00100, 16'h0000, 16'h1000, 1'b1);
        push(3'b010, 1'b0, 18'h01111, 16'h0000, 16'h1111, 1'b1);
        push(3'b100, 1'b0, 18'h02222, 16'h0000, 16'h2222, 1'b1);
        run("simultaneous", 3'b111, 3, 1'b1);

        // Starvation guard: 8 video, 1 erase, repeated (second round proves counter cleared)
        do_reset();
        for (int i = 0; i < 18; i++) begin
            if (i == 8 || i == 17) push(3'b100, 1'b0, 18'h02222, 16'h0000, 16'h2222, 1'b1);
            else                   push(3'b001, 1'b0, 18'h00100, 16'h0000, 16'h1000, 1'b1);
        end
        run("starvation", 3'b101, 18, 1'b0);

        // Reset while the access is in WAIT
        do_reset();
        push(3'b001, 1'b0, 18'h00100, 16'h0000, 16'h1000, 1'b0);
        req = 3'b001;
        for (int b = 0; b < 50 && gnt == 3'b000; b++) @(negedge clk);
        req = 3'b000;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy actual=%b required=1", busy);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check_idle("reset_mid_access");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        last_g = -100;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done != 3'b000) saw_done = 1'b1;
        end
        total++;
        if (saw_done) begin
            bad++;
            $display("FAIL done_after_reset actual=1 required=0");
        end
        gq.delete();
        push(3'b001, 1'b0, 18'h00100, 16'h0000, 16'h1000, 1'b1);
        run("post_reset", 3'b001, 1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
